instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- ADDR_W, 13, memory/PC address width.
- DATA_W, 16, instruction width.
- RESET_PC, 'h100, first fetch address after reset.
- MEM_LAT, 2, clock edges from request to valid read data (>=1).
- DEPTH, 2, instruction buffer entries.

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock; all state updates on the rising edge.
- rst, in, 1, reset, asynchronous, active-high.
- mem_addr, out, ADDR_W, read address to memory.
- mem_cs, out, 1, memory chip select.
- mem_oe, out, 1, memory output enable.
- mem_we, out, 1, memory write enable, constant 0.
- mem_rdata, in, DATA_W, memory read data.
- redirect_valid, in, 1, PC change request from execute (jump/skip).
- redirect_pc, in, ADDR_W, new fetch address.
- halt, in, 1, suspend issuing new fetches.
- instr_valid, out, 1, buffer head holds a valid instruction.
- instr, out, DATA_W, instruction at buffer head.
- instr_pc, out, ADDR_W, address the head instruction was fetched from.
- instr_ready, in, 1, consumer accepts head this cycle.

Function
REQ-003 FSM states: IDLE (no request outstanding) and WAIT (request outstanding); all outputs registered.
- IDLE -> WAIT when !halt && !redirect_valid && (count < DEPTH).
- On the IDLE -> WAIT edge: mem_addr <= pc, mem_cs <= 1, mem_oe <= 1, latency counter <= MEM_LAT-1.
REQ-004 In WAIT: mem_addr/mem_cs/mem_oe held stable; counter decrements each edge.
- On the edge where counter==0: push {mem_rdata, mem_addr} into buffer, pc <= pc+2 modulo 2^ADDR_W, mem_cs <= 0, mem_oe <= 0, go to IDLE.
REQ-005 At most one request outstanding; peak throughput one instruction per MEM_LAT+1 cycles.
REQ-006 Buffer is a DEPTH-entry FIFO. instr_valid = (count != 0); instr and instr_pc = head entry.
- Pop on instr_valid && instr_ready.
- Push and pop on the same edge are both performed; count unchanged.
REQ-007 A push when full is impossible by construction (REQ-003 gating); a pop when empty is ignored.
REQ-008 Head instr and instr_pc stay stable while instr_valid && !instr_ready.
REQ-009 redirect_valid has priority over all other events on that edge:
- FIFO flushed (count <= 0, the same-edge pop is void).
- pc <= {redirect_pc[ADDR_W-1:1], 1'b0}.
- Any in-flight request is abandoned: state <= IDLE, mem_cs/mem_oe <= 0, its data is never pushed.
- Fetching resumes from the new pc on the next edge if REQ-003 allows.
REQ-010 halt only blocks new issues; an in-flight request completes and pushes normally; buffer pops continue; fetching resumes the edge after halt falls.
REQ-011 PC wrap: the fetch at 2^ADDR_W-2 is followed by the fetch at 0.

Reset
REQ-012 While rst=1, asynchronously:
- state = IDLE, pc = RESET_PC, count = 0, counter = 0.
- mem_addr = 0, mem_cs = 0, mem_oe = 0, mem_we = 0.
- instr_valid = 0.
REQ-013 rst asserted mid-WAIT discards the request and buffer contents; the first request after release is to RESET_PC on the first rising edge with rst=0.

Verification
REQ-014 Reset release, memory 0x100=0x0128, 0x102=0x212A, instr_ready=1, MEM_LAT=2:
- mem_addr=0x100 with cs=oe=1 after edge 1.
- instr_valid=1, instr=0x0128, instr_pc=0x100 after edge 3.
- Next instruction 0x212A at pc 0x102 after edge 6.
REQ-015 instr_ready=0 from reset, memory 0x100..0x106 = 0x0128, 0x212A, 0x1128, 0x1130:
- Exactly 2 entries buffered (0x0128, 0x212A), then no further mem_cs.
- Head holds 0x0128 throughout.
- Raising instr_ready drains 0x0128, then 0x212A, then fetching of 0x104 resumes.
REQ-016 redirect_valid=1, redirect_pc=0x115 during WAIT for 0x104:
- Buffer flushed, 0x104 data never appears.
- Next mem_addr=0x114.
- First delivered instr_pc=0x114.
REQ-017 halt=1 asserted the cycle after an issue to 0x108:
- 0x108 instruction still delivered.
- No mem_cs until halt=0.
- Next fetch is 0x10A.
REQ-018 Redirect to 0x1FFE with ADDR_W=13: fetches 0x1FFE then 0x0000.
REQ-019 rst pulsed during WAIT with buffer full: instr_valid=0 immediately; first fetch after release is 0x100.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch unit feeding a small FIFO buffer
module instr_fetch #(
    parameter int                ADDR_W   = 13,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 'h100,
    parameter int                MEM_LAT  = 2,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_cs,
    output logic              mem_oe,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int LW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [LW-1:0] LAT_LOAD = LW'(MEM_LAT - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   pc;
    logic [LW-1:0]       lat;
    logic [CW-1:0]       count;
    logic [PW-1:0]       head;
    logic [PW-1:0]       tail;
    logic [DATA_W-1:0]   buf_instr [DEPTH];
    logic [ADDR_W-1:0]   buf_pc    [DEPTH];
    logic                push;
    logic                pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign mem_we      = 1'b0;
    assign push        = (state == WAIT) && (lat == '0);
    assign pop         = (count != '0) && instr_ready;
    assign instr_valid = (count != '0);
    assign instr       = buf_instr[head];
    assign instr_pc    = buf_pc[head];

    // Fetch FSM, memory request outputs and FIFO bookkeeping; redirect overrides everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            lat      <= '0;
            mem_addr <= '0;
            mem_cs   <= 1'b0;
            mem_oe   <= 1'b0;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else if (redirect_valid) begin
            state  <= IDLE;
            pc     <= {redirect_pc[ADDR_W-1:1], 1'b0};
            lat    <= '0;
            mem_cs <= 1'b0;
            mem_oe <= 1'b0;
            count  <= '0;
            head   <= '0;
            tail   <= '0;
        end else begin
            if (push) tail <= nxt(tail);
            if (pop) head <= nxt(head);
            count <= count + CW'(push) - CW'(pop);
            case (state)
                IDLE: if (!halt && count < FULL) begin
                    state    <= WAIT;
                    mem_addr <= pc;
                    mem_cs   <= 1'b1;
                    mem_oe   <= 1'b1;
                    lat      <= LAT_LOAD;
                end
                WAIT: if (lat == '0) begin
                    state  <= IDLE;
                    pc     <= pc + ADDR_W'(2);
                    mem_cs <= 1'b0;
                    mem_oe <= 1'b0;
                end else begin
                    lat <= lat - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Buffer storage; stale writes on flush/reset are harmless since count governs validity
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[tail] <= mem_rdata;
            buf_pc[tail]    <= mem_addr;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed table-driven checks of the fetch unit against a latency-2 memory model
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] mem_addr;
    logic        mem_cs, mem_oe, mem_we;
    logic [15:0] mem_rdata = 16'h0;
    logic        redirect_valid = 1'b0;
    logic [12:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        instr_valid;
    logic [15:0] instr;
    logic [12:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic [15:0] mem [8192];
    int          n_chk = 0;
    int          n_fail = 0;

    typedef struct {
        logic        rdy, h, rv;
        logic [12:0] rpc;
        logic        v;
        logic [15:0] ins;
        logic [12:0] ipc;
        logic        cs;
        logic [12:0] a;
    } vec_t;

    vec_t tbl [35];

    instr_fetch dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_oe(mem_oe),
        .mem_we(mem_we), .mem_rdata(mem_rdata), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt(halt), .instr_valid(instr_valid), .instr(instr),
        .instr_pc(instr_pc), .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    // Memory: address registered on one edge, data presented for the next edge (two-edge latency)
    always @(posedge clk) mem_rdata <= (mem_cs && mem_oe) ? mem[mem_addr] : 16'hDEAD;

    function automatic vec_t mk(input int rdy, h, rv, rpc, v, ins, ipc, cs, a);
        vec_t r;
        r.rdy = rdy[0]; r.h = h[0]; r.rv = rv[0]; r.rpc = 13'(rpc);
        r.v = v[0]; r.ins = 16'(ins); r.ipc = 13'(ipc); r.cs = cs[0]; r.a = 13'(a);
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = {3'b110, 13'(i)};
        mem[13'h100] = 16'h0128;
        mem[13'h102] = 16'h212A;
        mem[13'h104] = 16'h1128;
        mem[13'h106] = 16'h1130;

        tbl[0]  = mk(0,0,0,0,      0,0,0,          1,'h100);
        tbl[1]  = mk(0,0,0,0,      0,0,0,          1,'h100);
        tbl[2]  = mk(0,0,0,0,      1,'h0128,'h100, 0,'h100);
        tbl[3]  = mk(0,0,0,0,      1,'h0128,'h100, 1,'h102);
        tbl[4]  = mk(0,0,0,0,      1,'h0128,'h100, 1,'h102);
        tbl[5]  = mk(0,0,0,0,      1,'h0128,'h100, 0,'h102);
        tbl[6]  = mk(0,0,0,0,      1,'h0128,'h100, 0,'h102);
        tbl[7]  = mk(0,0,0,0,      1,'h0128,'h100, 0,'h102);
        tbl[8]  = mk(1,0,0,0,      1,'h212A,'h102, 0,'h102);
        tbl[9]  = mk(1,0,0,0,      0,0,0,          1,'h104);
        tbl[10] = mk(1,0,0,0,      0,0,0,          1,'h104);
        tbl[11] = mk(1,0,0,0,      1,'h1128,'h104, 0,'h104);
        tbl[12] = mk(1,0,0,0,      0,0,0,          1,'h106);
        tbl[13] = mk(1,0,0,0,      0,0,0,          1,'h106);
        tbl[14] = mk(1,0,0,0,      1,'h1130,'h106, 0,'h106);
        tbl[15] = mk(1,0,0,0,      0,0,0,          1,'h108);
        tbl[16] = mk(1,1,0,0,      0,0,0,          1,'h108);
        tbl[17] = mk(1,1,0,0,      1,'hC108,'h108, 0,'h108);
        tbl[18] = mk(1,1,0,0,      0,0,0,          0,'h108);
        tbl[19] = mk(1,1,0,0,      0,0,0,          0,'h108);
        tbl[20] = mk(1,0,0,0,      0,0,0,          1,'h10A);
        tbl[21] = mk(1,0,0,0,      0,0,0,          1,'h10A);
        tbl[22] = mk(1,0,0,0,      1,'hC10A,'h10A, 0,'h10A);
        tbl[23] = mk(0,0,0,0,      1,'hC10A,'h10A, 1,'h10C);
        tbl[24] = mk(0,0,1,'h115,  0,0,0,          0,'h10C);
        tbl[25] = mk(0,0,0,0,      0,0,0,          1,'h114);
        tbl[26] = mk(0,0,0,0,      0,0,0,          1,'h114);
        tbl[27] = mk(0,0,0,0,      1,'hC114,'h114, 0,'h114);
        tbl[28] = mk(1,0,1,'h1FFE, 0,0,0,          0,'h114);
        tbl[29] = mk(1,0,0,0,      0,0,0,          1,'h1FFE);
        tbl[30] = mk(1,0,0,0,      0,0,0,          1,'h1FFE);
        tbl[31] = mk(1,0,0,0,      1,'hDFFE,'h1FFE,0,'h1FFE);
        tbl[32] = mk(1,0,0,0,      0,0,0,          1,'h0);
        tbl[33] = mk(1,0,0,0,      0,0,0,          1,'h0);
        tbl[34] = mk(0,0,0,0,      1,'hC000,'h0,   0,'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("reset valid", 16'(instr_valid), 16'h0);
        chk("reset cs", 16'(mem_cs), 16'h0);
        chk("reset oe", 16'(mem_oe), 16'h0);
        chk("reset we", 16'(mem_we), 16'h0);
        chk("reset addr", 16'(mem_addr), 16'h0);
        rst = 1'b0;

        for (int i = 0; i < 35; i++) begin
            instr_ready    = tbl[i].rdy;
            halt           = tbl[i].h;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            @(posedge clk);
            #1;
            chk($sformatf("edge%0d valid", i + 1), 16'(instr_valid), 16'(tbl[i].v));
            chk($sformatf("edge%0d cs", i + 1), 16'(mem_cs), 16'(tbl[i].cs));
            chk($sformatf("edge%0d oe", i + 1), 16'(mem_oe), 16'(tbl[i].cs));
            chk($sformatf("edge%0d we", i + 1), 16'(mem_we), 16'h0);
            chk($sformatf("edge%0d addr", i + 1), 16'(mem_addr), 16'(tbl[i].a));
            if (tbl[i].v) begin
                chk($sformatf("edge%0d instr", i + 1), instr, tbl[i].ins);
                chk($sformatf("edge%0d instr_pc", i + 1), 16'(instr_pc), 16'(tbl[i].ipc));
            end
        end

        // Reset mid-request with a buffered instruction: output must clear without a clock edge
        instr_ready    = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pre-rst cs", 16'(mem_cs), 16'h1);
        chk("pre-rst addr", 16'(mem_addr), 16'h0002);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        chk("async rst valid", 16'(instr_valid), 16'h0);
        chk("async rst cs", 16'(mem_cs), 16'h0);
        chk("async rst oe", 16'(mem_oe), 16'h0);
        chk("async rst addr", 16'(mem_addr), 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        instr_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post-rst cs", 16'(mem_cs), 16'h1);
        chk("post-rst addr", 16'(mem_addr), 16'h0100);
        chk("post-rst valid", 16'(instr_valid), 16'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("post-rst valid2", 16'(instr_valid), 16'h1);
        chk("post-rst instr", instr, 16'h0128);
        chk("post-rst instr_pc", 16'(instr_pc), 16'h0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
